kernel_stream_ctrl: RTL and testbench

// - Sequences one pipelined kernel top (ivalid/iready in, ovalid/oready out) over a job of NITEMS work-items.
// - Sits between the input stream source, the kernel top and the output sink; gates both handshakes.
// - Issues exactly NITEMS inputs, collects exactly NITEMS outputs, caps items in flight, flags stalls.
// - Reports one-cycle done.

---
 rtl/tytra_ctrl_pkg.sv | 16 +
 rtl/kernel_flight_ctr.sv | 42 ++++
 rtl/kernel_stream_ctrl.sv | 136 +++++++++++++
 tb/tb_kernel_stream_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tytra_ctrl_pkg.sv
// Shared types and default widths for the kernel stream controller slice.
package tytra_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  localparam int DEF_CNTW      = 32;
  localparam int DEF_MAXFLIGHT = 16;
  localparam int DEF_FLIGHTW   = 5;
  localparam int DEF_WDOGW     = 16;

endpackage

// File: rtl/kernel_flight_ctr.sv
// Up/down counter of items issued to the kernel but not yet collected.
module kernel_flight_ctr
  import tytra_ctrl_pkg::*;
#(
  parameter int MAXFLIGHT = DEF_MAXFLIGHT,
  parameter int FLIGHTW   = DEF_FLIGHTW
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  logic [FLIGHTW-1:0] count_q, count_d;

  // Simultaneous issue and collect cancel out.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i) begin
      count_d = count_q + FLIGHTW'(1);
    end else if (dec_i && !inc_i) begin
      count_d = count_q - FLIGHTW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign full_o  = (count_q == FLIGHTW'(MAXFLIGHT));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/kernel_stream_ctrl.sv
// Sequences a pipelined kernel over a job of nitems work-items, gating both
// handshakes, capping items in flight and flagging stalls via a watchdog.
module kernel_stream_ctrl
  import tytra_ctrl_pkg::*;
#(
  parameter int CNTW      = DEF_CNTW,
  parameter int MAXFLIGHT = DEF_MAXFLIGHT,
  parameter int FLIGHTW   = DEF_FLIGHTW,
  parameter int WDOGW     = DEF_WDOGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CNTW-1:0] nitems,
  output logic            busy,
  output logic            done,
  output logic            stall_err,
  input  logic            src_valid,
  output logic            src_ready,
  output logic            k_ivalid,
  input  logic            k_iready,
  input  logic            k_ovalid,
  output logic            k_oready,
  output logic            snk_valid,
  input  logic            snk_ready,
  output logic [CNTW-1:0] issued,
  output logic [CNTW-1:0] collected
);

  ctrl_state_e      state_q, state_d;
  logic [CNTW-1:0]  n_q, n_d;
  logic [CNTW-1:0]  issued_q, issued_d;
  logic [CNTW-1:0]  collected_q, collected_d;
  logic [WDOGW-1:0] wdog_q, wdog_d;
  logic             stall_q, stall_d;
  logic             fl_full, fl_empty;
  logic             active, issue_en, collect_en, in_fire, out_fire, job_start;

  assign active     = (state_q == RUN) || (state_q == DRAIN);
  assign issue_en   = (state_q == RUN) && (issued_q != n_q) && !fl_full;
  assign collect_en = active && !fl_empty;
  assign job_start  = (state_q == IDLE) && start;

  assign src_ready = k_iready & issue_en;
  assign k_ivalid  = src_valid & issue_en;
  assign k_oready  = snk_ready & collect_en;
  assign snk_valid = k_ovalid & collect_en;
  assign in_fire   = k_ivalid & k_iready;
  assign out_fire  = k_ovalid & k_oready;

  assign busy      = active;
  assign done      = (state_q == DONE);
  assign stall_err = stall_q;
  assign issued    = issued_q;
  assign collected = collected_q;

  kernel_flight_ctr #(
    .MAXFLIGHT (MAXFLIGHT),
    .FLIGHTW   (FLIGHTW)
  ) u_flight (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (job_start),
    .inc_i   (in_fire),
    .dec_i   (out_fire),
    .full_o  (fl_full),
    .empty_o (fl_empty)
  );

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    issued_d    = issued_q;
    collected_d = collected_q;
    wdog_d      = '0;
    stall_d     = stall_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d         = nitems;
          issued_d    = '0;
          collected_d = '0;
          stall_d     = 1'b0;
          state_d     = (nitems == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        issued_d    = issued_q + CNTW'(in_fire);
        collected_d = collected_q + CNTW'(out_fire);
        if (issued_d == n_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        collected_d = collected_q + CNTW'(out_fire);
        if (collected_d == n_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Watchdog saturates at all-ones so the stall flag cannot be lost by wrap.
    if (active && !(in_fire || out_fire)) begin
      wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + WDOGW'(1);
      if (wdog_d == '1) begin
        stall_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      issued_q    <= '0;
      collected_q <= '0;
      wdog_q      <= '0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      issued_q    <= issued_d;
      collected_q <= collected_d;
      wdog_q      <= wdog_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_kernel_stream_ctrl.sv
// Randomized scoreboard bench for kernel_stream_ctrl with a job-level reference
// model and a behavioural latency-3 kernel.
module tb_kernel_stream_ctrl;

  localparam int CNTW  = 32;
  localparam int MAXF  = 4;
  localparam int FLW   = 3;
  localparam int WDW   = 4;
  localparam int WDMAX = (1 << WDW) - 1;
  localparam int KLAT  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [CNTW-1:0] nitems = '0;
  logic            busy, done, stall_err;
  logic            src_valid = 1'b0;
  logic            src_ready, k_ivalid;
  logic            k_iready = 1'b1;
  logic            k_ovalid = 1'b0;
  logic            k_oready, snk_valid;
  logic            snk_ready = 1'b1;
  logic [CNTW-1:0] issued, collected;

  int checks = 0;
  int failures = 0;

  // Reference model: job-level bookkeeping in plain integers.
  bit mActive = 0, mDoneCyc = 0, mStall = 0;
  int mN = 0, mIss = 0, mCol = 0, mIdle = 0;
  bit mIn = 0, mOut = 0, dutIn = 0, dutOut = 0, startS = 0;
  logic [CNTW-1:0] nitemsS = '0;
  int jobQ[$];
  int kq[$];
  int jobIns = 0, jobOuts = 0, cyc = 0;
  bit randMode = 0;

  kernel_stream_ctrl #(
    .CNTW      (CNTW),
    .MAXFLIGHT (MAXF),
    .FLIGHTW   (FLW),
    .WDOGW     (WDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .nitems    (nitems),
    .busy      (busy),
    .done      (done),
    .stall_err (stall_err),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .k_ivalid  (k_ivalid),
    .k_iready  (k_iready),
    .k_ovalid  (k_ovalid),
    .k_oready  (k_oready),
    .snk_valid (snk_valid),
    .snk_ready (snk_ready),
    .issued    (issued),
    .collected (collected)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit sv, input bit sr);
    @(posedge clk);
    #2;
    src_valid = sv;
    snk_ready = sr;
    k_iready  = 1'b1;
  endtask

  task automatic pulseStart(input int n);
    @(posedge clk);
    #2;
    start  = 1'b1;
    nitems = CNTW'(n);
    @(posedge clk);
    #2;
    start  = 1'b0;
  endtask

  task automatic waitDone(input int bound, input string name);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done) seen = 1;
    end
    checkOutput(name, seen, 1);
  endtask

  task automatic applyReset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    mActive = 0; mDoneCyc = 0; mStall = 0;
    mN = 0; mIss = 0; mCol = 0; mIdle = 0;
    kq.delete();
    jobQ.delete();
    k_ovalid = 1'b0;
    #1;
    checkOutput("rstKivalid", k_ivalid, 0);
    checkOutput("rstSrcReady", src_ready, 0);
    checkOutput("rstKoready", k_oready, 0);
    checkOutput("rstSnkValid", snk_valid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstIssued", issued, 0);
    checkOutput("rstCollected", collected, 0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  // Monitor: compares every visible output against the model and pops the
  // job scoreboard whenever the controller signals completion.
  always @(negedge clk) begin
    bit ie, ce;
    if (rst) begin
      ie = mActive && (mIss < mN) && ((mIss - mCol) < MAXF);
      ce = mActive && (mIss > mCol);
      checkOutput("busy", busy, mActive);
      checkOutput("done", done, mDoneCyc);
      checkOutput("stallErr", stall_err, mStall);
      checkOutput("srcReady", src_ready, k_iready & ie);
      checkOutput("kIvalid", k_ivalid, src_valid & ie);
      checkOutput("kOready", k_oready, snk_ready & ce);
      checkOutput("snkValid", snk_valid, k_ovalid & ce);
      checkOutput("issued", issued, mIss);
      checkOutput("collected", collected, mCol);
      mIn     = src_valid & ie & k_iready;
      mOut    = k_ovalid & ce & snk_ready;
      dutIn   = k_ivalid & k_iready;
      dutOut  = k_ovalid & k_oready;
      startS  = start;
      nitemsS = nitems;
      if (done) begin
        checkOutput("doneHasJob", jobQ.size() > 0, 1);
        if (jobQ.size() > 0) begin
          int n;
          n = jobQ.pop_front();
          checkOutput("jobIssued", issued, n);
          checkOutput("jobCollected", collected, n);
          checkOutput("jobSinkFires", jobOuts, n);
        end
      end
    end else begin
      mIn = 0; mOut = 0; dutIn = 0; dutOut = 0; startS = 0;
    end
  end

  // Edge update: advances the model and the behavioural kernel, then drives
  // random traffic and the kernel's ovalid shortly after the edge.
  always @(posedge clk) begin
    if (rst) begin
      cyc++;
      if (dutOut) begin
        void'(kq.pop_front());
        jobOuts++;
      end
      if (dutIn) begin
        kq.push_back(cyc + KLAT);
        jobIns++;
      end
      if (mDoneCyc) begin
        mDoneCyc = 0;
      end else if (!mActive) begin
        if (startS) begin
          mN = int'(nitemsS); mIss = 0; mCol = 0; mIdle = 0; mStall = 0;
          jobIns = 0; jobOuts = 0;
          jobQ.push_back(mN);
          if (mN == 0) mDoneCyc = 1;
          else mActive = 1;
        end
      end else begin
        if (mIn) mIss++;
        if (mOut) mCol++;
        if (!mIn && !mOut) begin
          mIdle++;
          if (mIdle >= WDMAX) mStall = 1;
        end else begin
          mIdle = 0;
        end
        checkOutput("inflightCap", (jobIns - jobOuts) <= MAXF, 1);
        if (mCol == mN) begin
          mActive  = 0;
          mDoneCyc = 1;
        end
      end
    end
    #2;
    if (randMode) begin
      src_valid = 1'($urandom_range(0, 1));
      snk_ready = 1'($urandom_range(0, 1));
      k_iready  = ($urandom_range(0, 3) != 0);
    end
    k_ovalid = 1'b0;
    if (rst && kq.size() > 0) begin
      if (kq[0] <= cyc) k_ovalid = 1'b1;
    end
  end

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetStall", stall_err, 0);
    checkOutput("resetIssued", issued, 0);
    checkOutput("resetCollected", collected, 0);
    checkOutput("resetKivalid", k_ivalid, 0);
    @(negedge clk);
    #2 rst = 1'b1;

    applyStimulus(1, 1);
    pulseStart(8);
    waitDone(200, "job8Done");
    @(negedge clk);
    checkOutput("job8IssuedHold", issued, 8);
    checkOutput("job8CollectedHold", collected, 8);

    pulseStart(0);
    waitDone(10, "job0Done");

    applyStimulus(1, 0);
    pulseStart(10);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("capInputFires", jobIns, MAXF);
    checkOutput("capSrcReady", src_ready, 0);
    applyStimulus(1, 1);
    waitDone(300, "job10Done");

    randMode = 1;
    pulseStart(100);
    waitDone(5000, "job100Done");
    randMode = 0;
    applyStimulus(1, 1);

    applyStimulus(0, 1);
    pulseStart(6);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("wdogStall", stall_err, 1);
    applyStimulus(1, 1);
    waitDone(200, "jobStallDone");
    @(negedge clk);
    checkOutput("stallSticky", stall_err, 1);
    pulseStart(1);
    @(negedge clk);
    checkOutput("stallCleared", stall_err, 0);
    waitDone(100, "job1Done");

    applyStimulus(1, 0);
    pulseStart(3);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("drainBusy", busy, 1);
    checkOutput("drainIssued", issued, 3);
    checkOutput("drainOvalid", k_ovalid, 1);
    applyReset();
    applyStimulus(1, 1);
    pulseStart(2);
    pulseStart(7);
    waitDone(100, "jobAfterRstDone");
    @(negedge clk);
    checkOutput("ignoredStartIssued", issued, 2);
    checkOutput("jobQueueEmpty", jobQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
